i2c_target_responder: RTL and testbench
=======================================

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h22, the 7-bit I2C address this block answers to.
REQ-002 SHALL have parameter DEPTH, default 16, the number of 8-bit register file entries (power of two, pointer width log2(DEPTH)).
REQ-003 SHALL have port clk_i, input, 1, the single system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port scl_i, input, 1, I2C clock line (bus value, asynchronous).
REQ-006 SHALL have port sda_i, input, 1, I2C data line (bus value, asynchronous).
REQ-007 SHALL have port sda_oe_o, input-free output, 1: 1 = pull SDA low, 0 = release (open drain; the block never drives SCL, no clock stretching).
REQ-008 SHALL have ports ld_en_i (1), ld_addr_i (log2 DEPTH), ld_data_i (8), inputs: local preload write into the register file.
REQ-009 SHALL have ports wr_valid_o (1), wr_addr_o (log2 DEPTH), wr_data_o (8), outputs: one-cycle strobe per byte written by the I2C controller.
REQ-010 SHALL have port busy_o, output, 1: high from an address-matched START until STOP or mismatch.

Function
REQ-011 SHALL pass scl_i and sda_i through 2-flop synchronizers plus one history flop; all detection uses the synchronized values.
REQ-012 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high; data bits are sampled on SCL rising edges.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-014 SHALL, on START (including repeated START) from any state, clear the bit counter and enter ADDR.
REQ-015 SHALL, on STOP from any state, release SDA and enter IDLE within one clk_i cycle.
REQ-016 SHALL in ADDR shift 8 bits MSB first; on 7-bit match go to ADDR_ACK, else go to WAIT_STOP without ever driving SDA.
REQ-017 SHALL assert sda_oe_o the cycle after the SCL falling edge ending the 8th bit, and hold it until the next SCL falling edge (one ACK bit time).
REQ-018 SHALL after ADDR_ACK enter RX if R/W bit = 0, TX if R/W bit = 1.
REQ-019 SHALL in RX treat the first byte after an address-with-write as the register pointer (low log2 DEPTH bits used) and every later byte as data written to regfile[pointer], then increment the pointer.
REQ-020 SHALL pulse wr_valid_o for exactly one cycle per data byte (not the pointer byte), with wr_addr_o/wr_data_o valid in that cycle, and ACK every received byte.
REQ-021 SHALL in TX drive regfile[pointer] MSB first, changing sda_oe_o only after SCL falling edges (sda_oe_o = ~bit), then increment the pointer.
REQ-022 SHALL in TX_ACK release SDA and sample the controller's ACK: ACK (0) -> next TX byte; NACK (1) -> WAIT_STOP.
REQ-023 SHALL wrap the pointer from DEPTH-1 to 0 in both RX and TX.
REQ-024 SHALL keep the pointer across transactions (a write of only a pointer byte followed by a repeated-START read reads from that pointer).
REQ-025 SHALL give an I2C data write priority over ld_en_i when both target the same entry in the same cycle; otherwise both complete.
REQ-026 SHALL not change sda_oe_o while synchronized SCL is high, except to release on STOP/reset.

Reset
REQ-027 SHALL on rst_i asynchronously force state IDLE, sda_oe_o = 0, wr_valid_o = 0, wr_addr_o = 0, wr_data_o = 0, busy_o = 0, pointer = 0, synchronizers to 1.
REQ-028 SHALL clear all register file entries to 8'h00 on reset.
REQ-029 SHALL, on reset mid-transfer, ignore the bus until the next START after rst_i deasserts.

Verification
REQ-030 SHALL pass: write 0x44, 0x03, 0xA5, 0x5A -> ACK all four; wr_valid_o twice: (3, 0xA5), (4, 0x5A).
REQ-031 SHALL pass: preload regfile[4]=0x77 via ld_*, write 0x44, 0x04, repeated START, read 0x45, two bytes ACK/NACK -> returns 0x77 then regfile[5], SDA released after NACK.
REQ-032 SHALL pass: address 0x46 (target 0x23) -> sda_oe_o stays 0 for the whole transfer, busy_o stays 0, no wr_valid_o.
REQ-033 SHALL pass: pointer 0x0F then three data bytes -> writes at addresses 15, 0, 1.
REQ-034 SHALL pass: STOP issued mid-byte during TX -> sda_oe_o = 0 within one cycle, state IDLE, next transaction decodes normally.
REQ-035 SHALL pass: rst_i asserted while driving ACK -> sda_oe_o drops in the same cycle without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/i2c_target_responder.sv
// I2C target with a small byte-wide register file: pointer byte then data on write,
// sequential reads from the pointer, pointer kept across transactions.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         DEPTH       = 16,
    localparam int        PW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic          ld_en_i,
    input  logic [PW-1:0] ld_addr_i,
    input  logic [7:0]    ld_data_i,
    output logic          wr_valid_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_hist, sda_hist;
    logic [1:0] settle;
    logic       armed, scl, sda;
    logic       scl_rise, scl_fall, start, stop;

    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [7:0]            shreg, shreg_n;
    logic [7:0]            tx_byte, tx_byte_n;
    logic [PW-1:0]         ptr, ptr_n;
    logic                  ptr_byte, ptr_byte_n;
    logic                  rw, rw_n;
    logic                  sda_oe, sda_oe_n;
    logic                  busy, busy_n;
    logic                  rx_we;
    logic [DEPTH-1:0][7:0] regfile;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
            settle   <= 2'd0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    // Edges are ignored until the synchronizer chain holds only post-reset bus samples,
    // so a bus caught mid-transfer cannot fake a START.
    assign armed    = (settle == 2'd3);
    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = armed & scl & ~scl_hist;
    assign scl_fall = armed & ~scl & scl_hist;
    assign start    = armed & scl & scl_hist & sda_hist & ~sda;
    assign stop     = armed & scl & scl_hist & ~sda_hist & sda;

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        tx_byte_n  = tx_byte;
        ptr_n      = ptr;
        ptr_byte_n = ptr_byte;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        rx_we      = 1'b0;
        if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR, RX: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == RX) begin
                            state_n  = RX_ACK;
                            sda_oe_n = 1'b1;
                            if (ptr_byte) begin
                                ptr_n      = shreg[PW-1:0];
                                ptr_byte_n = 1'b0;
                            end else begin
                                rx_we = 1'b1;
                                ptr_n = ptr + PW'(1);
                            end
                        end else if (shreg[7:1] == TARGET_ADDR) begin
                            state_n  = ADDR_ACK;
                            sda_oe_n = 1'b1;
                            rw_n     = shreg[0];
                            busy_n   = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 4'd0;
                        if (rw) begin
                            state_n   = TX;
                            tx_byte_n = regfile[ptr];
                            sda_oe_n  = ~regfile[ptr][7];
                        end else begin
                            state_n    = RX;
                            sda_oe_n   = 1'b0;
                            ptr_byte_n = 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_n   = RX;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n  = TX_ACK;
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + PW'(1);
                        end else begin
                            sda_oe_n = ~tx_byte[3'd7 - bit_cnt[2:0]];
                        end
                    end
                end
                TX_ACK: begin
                    // A NACK ends the read at once; an ACK holds here until SCL falls.
                    if (scl_rise && sda) begin
                        state_n = WAIT_STOP;
                    end else if (scl_fall) begin
                        state_n   = TX;
                        bit_cnt_n = 4'd0;
                        tx_byte_n = regfile[ptr];
                        sda_oe_n  = ~regfile[ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            tx_byte    <= 8'h00;
            ptr        <= '0;
            ptr_byte   <= 1'b0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= 8'h00;
            regfile    <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            tx_byte    <= tx_byte_n;
            ptr        <= ptr_n;
            ptr_byte   <= ptr_byte_n;
            rw         <= rw_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            wr_valid_o <= rx_we;
            if (rx_we) begin
                wr_addr_o <= ptr;
                wr_data_o <= shreg;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (rx_we && ptr == PW'(i))
                    regfile[i] <= shreg;
                else if (ld_en_i && ld_addr_i == PW'(i))
                    regfile[i] <= ld_data_i;
            end
        end
    end

    assign sda_oe_o = sda_oe;
    assign busy_o   = busy;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: bit-banged I2C controller on a wired-AND SDA, hand-computed expectations.
module tb_i2c_target_responder;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = 4'd0;
    logic [7:0] ld_data = 8'h00;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    logic [11:0] wr_log[$];

    always #5 clk = ~clk;
    assign sda_bus = sda_c & ~sda_oe;

    i2c_target_responder dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_c), .sda_i(sda_bus), .sda_oe_o(sda_oe),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
    );

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; wait_q(Q);
        scl_c = 1'b1; wait_q(Q);
        sda_c = 1'b0; wait_q(Q);
        scl_c = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wait_q(Q);
        scl_c = 1'b1; wait_q(Q);
        sda_c = 1'b1; wait_q(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_c = b;    wait_q(Q);
        scl_c = 1'b1; wait_q(2 * Q);
        scl_c = 1'b0; wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_c = 1'b1; wait_q(Q);
        scl_c = 1'b1; wait_q(Q);
        b = sda_bus;  wait_q(Q);
        scl_c = 1'b0; wait_q(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(ack);
    endtask

    // Sets the pointer, repeated START, reads n bytes (ACK all but the last).
    task automatic read_from(input logic [7:0] p, input int n, output logic [7:0] d[4]);
        logic a;
        i2c_start();
        write_byte(8'h44, a); chk("rd_addr_w_ack", a, 1'b0);
        write_byte(p, a);     chk("rd_ptr_ack", a, 1'b0);
        i2c_start();
        write_byte(8'h45, a); chk("rd_addr_r_ack", a, 1'b0);
        for (int i = 0; i < n; i++) read_byte(i == n - 1, d[i]);
        i2c_stop();
    endtask

    initial begin
        logic a, seen, b;
        logic [7:0] d[4];
        logic [7:0] r;
        int base, oe0, busy0;

        wait_q(4);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_q(10);

        // Pointer 3, two data bytes.
        i2c_start();
        write_byte(8'h44, a); chk("w1_addr_ack", a, 1'b0);
        chk("w1_busy", busy, 1'b1);
        write_byte(8'h03, a); chk("w1_ptr_ack", a, 1'b0);
        write_byte(8'hA5, a); chk("w1_d0_ack", a, 1'b0);
        write_byte(8'h5A, a); chk("w1_d1_ack", a, 1'b0);
        i2c_stop();
        wait_q(4);
        chk("w1_busy_after_stop", busy, 1'b0);
        chk("w1_wr_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            chk("w1_wr0", wr_log[0], 12'h3A5);
            chk("w1_wr1", wr_log[1], 12'h45A);
        end

        // Preload then read back across a repeated START.
        @(negedge clk); ld_en = 1'b1; ld_addr = 4'd4; ld_data = 8'h77;
        @(negedge clk); ld_addr = 4'd5; ld_data = 8'hC3;
        @(negedge clk); ld_en = 1'b0;
        base = wr_log.size();
        i2c_start();
        write_byte(8'h44, a); chk("r1_addr_w_ack", a, 1'b0);
        write_byte(8'h04, a); chk("r1_ptr_ack", a, 1'b0);
        i2c_start();
        write_byte(8'h45, a); chk("r1_addr_r_ack", a, 1'b0);
        read_byte(1'b0, r);   chk("r1_byte0", r, 8'h77);
        read_byte(1'b1, r);   chk("r1_byte1", r, 8'hC3);
        chk("r1_released_after_nack", sda_oe, 1'b0);
        i2c_stop();
        chk("r1_no_writes", wr_log.size(), base);

        // Wrong address: never drives, never busy, never writes.
        base = wr_log.size(); oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h46, a); chk("nm_addr_nack", a, 1'b1);
        write_byte(8'h01, a); chk("nm_d0_nack", a, 1'b1);
        write_byte(8'hFF, a); chk("nm_d1_nack", a, 1'b1);
        i2c_stop();
        chk("nm_oe_cycles", oe_cnt - oe0, 0);
        chk("nm_busy_cycles", busy_cnt - busy0, 0);
        chk("nm_no_writes", wr_log.size(), base);

        // Pointer wrap on write and on read.
        base = wr_log.size();
        i2c_start();
        write_byte(8'h44, a);
        write_byte(8'h0F, a);
        write_byte(8'h11, a); chk("wrap_d0_ack", a, 1'b0);
        write_byte(8'h22, a);
        write_byte(8'h33, a); chk("wrap_d2_ack", a, 1'b0);
        i2c_stop();
        chk("wrap_wr_count", wr_log.size() - base, 3);
        if (wr_log.size() - base == 3) begin
            chk("wrap_wr0", wr_log[base], 12'hF11);
            chk("wrap_wr1", wr_log[base + 1], 12'h022);
            chk("wrap_wr2", wr_log[base + 2], 12'h133);
        end
        read_from(8'h0F, 3, d);
        chk("wrap_rd0", d[0], 8'h11);
        chk("wrap_rd1", d[1], 8'h22);
        chk("wrap_rd2", d[2], 8'h33);

        // Same-entry race: the I2C write must beat a local load held through it.
        seen = 1'b0;
        fork
            begin
                i2c_start();
                write_byte(8'h44, a);
                write_byte(8'h02, a);
                write_byte(8'h5C, a);
                i2c_stop();
            end
            begin
                @(negedge clk); ld_en = 1'b1; ld_addr = 4'd2; ld_data = 8'hEE;
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge clk);
                    if (wr_valid) seen = 1'b1;
                end
                ld_en = 1'b0;
            end
        join
        chk("race_wr_seen", seen, 1'b1);
        read_from(8'h02, 1, d);
        chk("race_i2c_wins", d[0], 8'h5C);

        // STOP in the middle of a TX byte (0x77: bit7=0, bit6=1, bit5=1 released).
        i2c_start();
        write_byte(8'h44, a);
        write_byte(8'h04, a);
        i2c_start();
        write_byte(8'h45, a); chk("ms_addr_ack", a, 1'b0);
        read_bit(b); chk("ms_bit7", b, 1'b0);
        read_bit(b); chk("ms_bit6", b, 1'b1);
        i2c_stop();
        chk("ms_oe_after_stop", sda_oe, 1'b0);
        chk("ms_busy_after_stop", busy, 1'b0);
        base = wr_log.size();
        i2c_start();
        write_byte(8'h44, a); chk("ms_next_addr_ack", a, 1'b0);
        write_byte(8'h07, a);
        write_byte(8'h6E, a); chk("ms_next_data_ack", a, 1'b0);
        i2c_stop();
        chk("ms_next_wr_count", wr_log.size() - base, 1);
        if (wr_log.size() - base == 1) chk("ms_next_wr", wr_log[base], 12'h76E);

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(r_bit(8'h44, i));
        sda_c = 1'b1; wait_q(2);
        chk("ar_oe_before_rst", sda_oe, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        chk("ar_oe_async", sda_oe, 1'b0);
        chk("ar_busy_async", busy, 1'b0);
        chk("ar_wr_addr_async", wr_addr, 4'h0);
        chk("ar_wr_data_async", wr_data, 8'h00);
        chk("ar_wr_valid_async", wr_valid, 1'b0);
        wait_q(3);
        rst = 1'b0;
        oe0 = oe_cnt;
        // Controller keeps clocking the old transfer; target must stay silent.
        write_bit(1'b0);
        for (int i = 7; i >= 0; i--) write_bit(r_bit(8'h03, i));
        write_bit(1'b1);
        i2c_stop();
        chk("ar_ignored_oe", oe_cnt - oe0, 0);

        // Pointer and register file back at reset values.
        @(negedge clk); ld_en = 1'b1; ld_addr = 4'd0; ld_data = 8'hA1;
        @(negedge clk); ld_en = 1'b0;
        i2c_start();
        write_byte(8'h45, a); chk("ar_read_addr_ack", a, 1'b0);
        read_byte(1'b0, r);   chk("ar_ptr0_byte", r, 8'hA1);
        read_byte(1'b1, r);   chk("ar_cleared_byte1", r, 8'h00);
        i2c_stop();
        read_from(8'h07, 1, d);
        chk("ar_cleared_byte7", d[0], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic r_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
